// File: rtl/seed_random_1_hand_scorer.sv
// Card-hand scorer: requests a random card, rejects out-of-range ranks, and totals the hand.
// Optional soft-ace scoring is enabled by defining SEED_RANDOM_SOFT_ACE_EN.
module seed_random_1_hand_scorer #(
  parameter int MAX_CARDS = 11,
  parameter int RETRY_MAX = 4
) (
  input  logic       clk_hs_i,
  input  logic       rst_hs_i,
  input  logic       deal_i,
  input  logic       new_hand_i,
  input  logic [7:0] next_card_i,
  output logic       req_card_state_dp_c_o,
  output logic [3:0] card_rank_o,
  output logic       card_valid_o,
  output logic [5:0] score_o,
  output logic [3:0] card_count_o,
  output logic       bust_o,
  output logic [2:0] dbg_state_o
);

  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [RW-1:0] RETRY_C = RW'(RETRY_MAX);
  localparam logic [3:0] MAX_C = 4'(MAX_CARDS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    SAMPLE = 3'd2,
    RETRY  = 3'd3,
    ACCUM  = 3'd4,
    BUST   = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic [3:0]    rank_q, rank_d;
  logic          valid_q, valid_d;
  logic [5:0]    score_q, score_d;
  logic [3:0]    count_q, count_d;
  logic          bust_q, bust_d;
  logic [3:0]    pend_q, pend_d;
  logic [RW-1:0] retry_q, retry_d;

  logic [3:0] raw;
  logic [4:0] card_val;
  logic [6:0] sum;
  logic       unused_hi_bits;

  assign raw            = next_card_i[3:0];
  assign unused_hi_bits = ^next_card_i[7:4];

`ifdef SEED_RANDOM_SOFT_ACE_EN
  localparam logic [4:0] ACE_VAL = 5'd11;
  logic [3:0] soft_q, soft_d, soft_tmp;
`else
  localparam logic [4:0] ACE_VAL = 5'd1;
`endif

  always_comb begin
    state_d  = state_q;
    rank_d   = rank_q;
    valid_d  = 1'b0;
    score_d  = score_q;
    count_d  = count_q;
    bust_d   = bust_q;
    pend_d   = pend_q;
    retry_d  = retry_q;
    card_val = 5'd0;
    sum      = 7'd0;
`ifdef SEED_RANDOM_SOFT_ACE_EN
    soft_d   = soft_q;
    soft_tmp = soft_q;
`endif
    case (state_q)
      IDLE: if (deal_i && (count_q < MAX_C)) state_d = REQ;
      REQ: if (!deal_i) state_d = SAMPLE;
      SAMPLE: begin
        if (raw <= 4'd12) begin
          pend_d  = raw + 4'd1;
          retry_d = '0;
          state_d = ACCUM;
        end else if (retry_q >= RETRY_C) begin
          // Out of retries: fold the high raw values down onto ranks 1..3.
          pend_d  = raw - 4'd12;
          retry_d = '0;
          state_d = ACCUM;
        end else begin
          retry_d = retry_q + 1'b1;
          state_d = RETRY;
        end
      end
      RETRY: state_d = SAMPLE;
      ACCUM: begin
        case (pend_q)
          4'd1:                card_val = ACE_VAL;
          4'd11, 4'd12, 4'd13: card_val = 5'd10;
          default:             card_val = {1'b0, pend_q};
        endcase
        sum = {1'b0, score_q} + {2'b00, card_val};
`ifdef SEED_RANDOM_SOFT_ACE_EN
        if (pend_q == 4'd1) soft_tmp = soft_q + 4'd1;
        if ((sum > 7'd21) && (soft_tmp != 4'd0)) begin
          sum      = sum - 7'd10;
          soft_tmp = soft_tmp - 4'd1;
        end
        soft_d = soft_tmp;
`endif
        score_d = sum[5:0];
        count_d = count_q + 4'd1;
        rank_d  = pend_q;
        valid_d = 1'b1;
        bust_d  = (sum > 7'd21);
        state_d = bust_d ? BUST : IDLE;
      end
      BUST:    state_d = BUST;
      default: state_d = IDLE;
    endcase

    // A new hand overrides everything, including a card still in flight.
    if (new_hand_i) begin
      state_d = IDLE;
      rank_d  = 4'd0;
      valid_d = 1'b0;
      score_d = 6'd0;
      count_d = 4'd0;
      bust_d  = 1'b0;
      pend_d  = 4'd0;
      retry_d = '0;
`ifdef SEED_RANDOM_SOFT_ACE_EN
      soft_d  = 4'd0;
`endif
    end

    req_d = (state_d == REQ) || (state_d == RETRY);
  end

  always_ff @(posedge clk_hs_i) begin
    if (rst_hs_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      rank_q  <= 4'd0;
      valid_q <= 1'b0;
      score_q <= 6'd0;
      count_q <= 4'd0;
      bust_q  <= 1'b0;
      pend_q  <= 4'd0;
      retry_q <= '0;
`ifdef SEED_RANDOM_SOFT_ACE_EN
      soft_q  <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rank_q  <= rank_d;
      valid_q <= valid_d;
      score_q <= score_d;
      count_q <= count_d;
      bust_q  <= bust_d;
      pend_q  <= pend_d;
      retry_q <= retry_d;
`ifdef SEED_RANDOM_SOFT_ACE_EN
      soft_q  <= soft_d;
`endif
    end
  end

  assign req_card_state_dp_c_o = req_q;
  assign card_rank_o           = rank_q;
  assign card_valid_o          = valid_q;
  assign score_o               = score_q;
  assign card_count_o          = count_q;
  assign bust_o                = bust_q;
  assign dbg_state_o           = state_q;

endmodule
